// File: rtl/pl_md_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
// Holds funct3 encodings, the controller state type and the iteration count.
// Helper functions decode operand signedness from funct3.
package pl_md_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

    // Operation context captured when an op is accepted.
    typedef struct packed {
        logic [2:0] funct3;
        logic [4:0] rd;
        logic       a_neg;
        logic       b_neg;
    } md_op_t;

    // rs1 is two's complement for MULH, MULHSU, DIV and REM.
    function automatic logic a_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // rs2 is two's complement for MULH, DIV and REM only.
    function automatic logic b_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/pl_muldiv_ex_if.sv
// Execute-stage bundle between the pipeline and the multiply/divide unit.
// Pipeline drives the op; the unit answers with stall, done pulse and result.
// The pipeline holds the op stable for as long as StallMD is high.
interface pl_muldiv_ex_if;

    logic        MdE;
    logic [2:0]  funct3E;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic [4:0]  RdE;
    logic        FlushE;
    logic        StallMD;
    logic        MdDoneE;
    logic [31:0] MdResultE;
    logic [4:0]  MdRdE;

    // Pipeline side: issues the op, observes stall and completion.
    modport master (
        output MdE, funct3E, SrcAE, SrcBE, RdE, FlushE,
        input  StallMD, MdDoneE, MdResultE, MdRdE
    );

    // Unit side: consumes the op, produces stall and completion.
    modport slave (
        input  MdE, funct3E, SrcAE, SrcBE, RdE, FlushE,
        output StallMD, MdDoneE, MdResultE, MdRdE
    );

endinterface

// File: rtl/pl_md_divstep.sv
// One restoring-division step on unsigned magnitudes.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle the divider iterates.
module pl_md_divstep (
    input  logic [31:0] rem_in,
    input  logic [31:0] divisor,
    input  logic        din,
    output logic [31:0] rem_out,
    output logic        q_bit
);

    logic [32:0] shifted;
    logic [32:0] diff;

    // Shift in the next dividend bit, trial-subtract, keep difference if non-negative.
    // The running remainder is always below the divisor, so the kept value fits 32 bits.
    always_comb begin
        shifted = {rem_in, din};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[32];
        rem_out = q_bit ? diff[31:0] : shifted[31:0];
    end

endmodule

// File: rtl/pl_muldiv_ex.sv
// Iterative RV32M multiply/divide unit living in the execute stage.
// Latency: 33 cycles accept-to-done for iterative ops, 1 cycle for div-by-zero/overflow.
// Backpressure: StallMD freezes the front of the pipeline while an op is in flight.
module pl_muldiv_ex
    import pl_md_pkg::*;
(
    input  logic          clk,
    input  logic          clr_n,
    pl_muldiv_ex_if.slave md
);

    md_state_t   state;
    md_state_t   state_nxt;
    md_op_t      op;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [31:0] opnd;
    logic [31:0] result_q;
    logic [4:0]  rd_q;

    logic        accept;
    logic        last_iter;
    logic        stall;
    logic        done;

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        is_div_op;
    logic        is_rem_in;
    logic        div_zero;
    logic        div_ovf;
    logic        special;
    logic [31:0] special_res;

    logic [32:0] mul_sum;
    logic [63:0] mul_nxt;
    logic [63:0] mul_prod;
    logic [31:0] mul_res;

    logic [31:0] dstep_rem;
    logic        dstep_q;
    logic [63:0] div_nxt;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] div_res;

    pl_md_divstep u_divstep (
        .rem_in  (acc[63:32]),
        .divisor (opnd),
        .din     (acc[31]),
        .rem_out (dstep_rem),
        .q_bit   (dstep_q)
    );

    // Decode the incoming op: magnitudes, signs and the two short-circuit cases.
    always_comb begin
        a_neg     = a_is_signed(md.funct3E) & md.SrcAE[31];
        b_neg     = b_is_signed(md.funct3E) & md.SrcBE[31];
        a_mag     = a_neg ? (~md.SrcAE + 32'd1) : md.SrcAE;
        b_mag     = b_neg ? (~md.SrcBE + 32'd1) : md.SrcBE;
        is_div_op = md.funct3E inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
        is_rem_in = md.funct3E inside {F3_REM, F3_REMU};
        div_zero  = is_div_op && (md.SrcBE == 32'd0);
        div_ovf   = (md.funct3E inside {F3_DIV, F3_REM})
                    && (md.SrcAE == 32'h8000_0000) && (md.SrcBE == 32'hFFFF_FFFF);
        special   = div_zero || div_ovf;
        if (div_zero) begin
            special_res = is_rem_in ? md.SrcAE : 32'hFFFF_FFFF;
        end else begin
            special_res = is_rem_in ? 32'd0 : 32'h8000_0000;
        end
    end

    // One shift-add multiply step and one restoring divide step on the shared register,
    // plus the sign fix-up applied to the value that lands on the final iteration.
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        mul_nxt  = {mul_sum, acc[31:1]};
        mul_prod = (op.a_neg ^ op.b_neg) ? (~mul_nxt + 64'd1) : mul_nxt;
        mul_res  = (op.funct3 == F3_MUL) ? mul_prod[31:0] : mul_prod[63:32];

        div_nxt  = {dstep_rem, acc[30:0], dstep_q};
        quo_s    = (op.a_neg ^ op.b_neg) ? (~div_nxt[31:0] + 32'd1) : div_nxt[31:0];
        rem_s    = op.a_neg ? (~div_nxt[63:32] + 32'd1) : div_nxt[63:32];
        div_res  = (op.funct3 inside {F3_REM, F3_REMU}) ? rem_s : quo_s;
    end

    // Controller next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        last_iter = (cnt == 5'(MD_ITER - 1));
        unique case (state)
            ST_IDLE: begin
                if (md.MdE && !md.FlushE) begin
                    accept = 1'b1;
                    stall  = 1'b1;
                    if (special) begin
                        state_nxt = ST_DONE;
                    end else if (is_div_op) begin
                        state_nxt = ST_DIV;
                    end else begin
                        state_nxt = ST_MUL;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (md.FlushE) begin
                    state_nxt = ST_IDLE;
                end else begin
                    stall = 1'b1;
                    if (last_iter) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done      = ~md.FlushE;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: capture on accept, iterate, and publish the result on the way into DONE.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            op       <= '0;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op  <= {md.funct3E, md.RdE, a_neg, b_neg};
                        cnt <= '0;
                        if (special) begin
                            result_q <= special_res;
                            rd_q     <= md.RdE;
                        end else if (is_div_op) begin
                            acc  <= {32'd0, a_mag};
                            opnd <= b_mag;
                        end else begin
                            acc  <= {32'd0, b_mag};
                            opnd <= a_mag;
                        end
                    end
                end
                ST_MUL: begin
                    if (!md.FlushE) begin
                        acc <= mul_nxt;
                        cnt <= cnt + 5'd1;
                        if (last_iter) begin
                            result_q <= mul_res;
                            rd_q     <= op.rd;
                        end
                    end
                end
                ST_DIV: begin
                    if (!md.FlushE) begin
                        acc <= div_nxt;
                        cnt <= cnt + 5'd1;
                        if (last_iter) begin
                            result_q <= div_res;
                            rd_q     <= op.rd;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Reset overrides the stall and done indications in the same cycle.
    assign md.StallMD   = stall & clr_n;
    assign md.MdDoneE   = done & clr_n;
    assign md.MdResultE = result_q;
    assign md.MdRdE     = rd_q;

endmodule
